aes_enc_round_ctrl: RTL

Round sequencer for the iterative AES-128 encryption datapath behind the AES_ENC AXI4-Lite slave. It accepts a start pulse decoded from the register bank and drives the datapath through one load, NUM_ROUNDS round handshakes and one ciphertext capture. It generates the round index, last-round flag and round constant (Rcon). It reports status and an interrupt back to the register bank, and enforces abort and watchdog-timeout recovery.

---
 rtl/aes_enc_round_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/aes_enc_round_ctrl.sv
// Round sequencer for the iterative AES-128 encryption datapath.
// Sequences one load, NUM_ROUNDS round handshakes and one ciphertext capture,
// generates round index / last-round flag / Rcon, and keeps sticky status flags,
// a level interrupt, abort handling and a watchdog on the round handshake.
module aes_enc_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       start,
  input  logic       abort,
  input  logic       irq_en,
  input  logic       irq_clr,
  input  logic       round_ack,
  output logic       load,
  output logic       round_go,
  output logic [3:0] round_idx,
  output logic       last_round,
  output logic [7:0] rcon,
  output logic       capture,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       overrun,
  output logic       timeout,
  output logic       irq
);

  localparam logic [3:0] LastRound  = 4'(NUM_ROUNDS);
  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StWait,
    StCapture
  } state_e;

  state_e     r_state;
  logic [3:0] r_round;
  logic [7:0] r_rcon;
  logic [7:0] r_wait_cnt;
  logic       r_done;
  logic       r_aborted;
  logic       r_overrun;
  logic       r_timeout;
  logic       r_irq;

  logic [7:0] w_xtime;
  logic [7:0] w_cnt_inc;
  logic       w_last;

  // GF(2^8) doubling of the current round constant
  assign w_xtime   = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);
  // Wait counter saturates at its maximum instead of wrapping
  assign w_cnt_inc = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;
  assign w_last    = (r_round == LastRound);

  // Sequencer state, round/Rcon generation, sticky flags and interrupt
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state    <= StIdle;
      r_round    <= 4'd0;
      r_rcon     <= 8'h01;
      r_wait_cnt <= 8'd0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_overrun  <= 1'b0;
      r_timeout  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      // A set later in this block overrides the clear
      if (irq_clr) begin
        r_irq <= 1'b0;
      end

      if (r_state == StIdle) begin
        // abort together with start in IDLE: start ignored, flags untouched
        if (start && !abort) begin
          r_state   <= StLoad;
          r_done    <= 1'b0;
          r_aborted <= 1'b0;
          r_overrun <= 1'b0;
          r_timeout <= 1'b0;
        end
      end else if (abort) begin
        r_state   <= StIdle;
        r_aborted <= 1'b1;
        r_round   <= 4'd0;
        r_rcon    <= 8'h01;
      end else begin
        if (start) begin
          r_overrun <= 1'b1;
        end
        unique case (r_state)
          StLoad: begin
            r_round <= 4'd1;
            r_rcon  <= 8'h01;
            r_state <= StRun;
          end
          StRun: begin
            r_wait_cnt <= 8'd0;
            r_state    <= StWait;
          end
          StWait: begin
            if (round_ack) begin
              if (w_last) begin
                r_state <= StCapture;
              end else begin
                r_round <= r_round + 4'd1;
                r_rcon  <= w_xtime;
                r_state <= StRun;
              end
            end else begin
              r_wait_cnt <= w_cnt_inc;
              if (w_cnt_inc >= TimeoutLim) begin
                r_state   <= StIdle;
                r_timeout <= 1'b1;
                r_round   <= 4'd0;
                r_rcon    <= 8'h01;
              end
            end
          end
          StCapture: begin
            r_state <= StIdle;
            r_done  <= 1'b1;
            r_round <= 4'd0;
            r_rcon  <= 8'h01;
            if (irq_en) begin
              r_irq <= 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Moore outputs decoded from the registered state
  assign load       = (r_state == StLoad);
  assign round_go   = (r_state == StRun);
  assign capture    = (r_state == StCapture);
  assign busy       = (r_state != StIdle);
  assign last_round = round_go && w_last;
  assign round_idx  = r_round;
  assign rcon       = r_rcon;
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign overrun    = r_overrun;
  assign timeout    = r_timeout;
  assign irq        = r_irq;

endmodule
